ha_array_reducer: RTL and testbench

- Consumer end of the half-adder-array partial-product interface of the unsigned 8x8 approximate multipliers.
- Accepts one bundle of four ha_array (b, t) row pairs and accumulates them into the final 16-bit product.
- Accumulation is multicycle and throttled by ROWS_PER_CYCLE.
- Sits between a multiplier's ha_array generator and the product consumer; valid/ready on both sides.

---
 rtl/ha_array_reducer_pkg.sv | 24 ++
 rtl/ha_array_reducer_if.sv | 36 +++
 rtl/ha_array_reducer_row_value.sv | 18 +
 rtl/ha_array_reducer.sv | 142 ++++++++++++++
 tb/tb_ha_array_reducer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ha_array_reducer_pkg.sv
// Shared types and constants for the half-adder-array partial-product reducer.
package ha_array_pkg;

  localparam int unsigned N_ARRAYS  = 4;
  localparam int unsigned T_W       = 9;
  localparam int unsigned B_W       = 7;
  localparam int unsigned B_SHIFT   = 2;
  localparam int unsigned ROW_SHIFT = 2;
  localparam int unsigned ACC_W     = 17;
  localparam int unsigned PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One ha_array: carry row b (weight +2 over t) and sum row t.
  typedef struct packed {
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } ha_row_t;

endpackage

// File: rtl/ha_array_reducer_if.sv
// Bundle-in / product-out handshake bus of the ha_array reducer.
// master: producer of row bundles and consumer of products; slave: the reducer.
interface ha_array_reducer_if;
  import ha_array_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [B_W-1:0]    ha_array_0_b;
  logic [B_W-1:0]    ha_array_1_b;
  logic [B_W-1:0]    ha_array_2_b;
  logic [B_W-1:0]    ha_array_3_b;
  logic [T_W-1:0]    ha_array_0_t;
  logic [T_W-1:0]    ha_array_1_t;
  logic [T_W-1:0]    ha_array_2_t;
  logic [T_W-1:0]    ha_array_3_t;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] prod;
  logic              ovf;
  logic              busy;

  modport master (
    output in_valid, out_ready,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  in_ready, out_valid, prod, ovf, busy
  );

  modport slave (
    input  in_valid, out_ready,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output in_ready, out_valid, prod, ovf, busy
  );

endinterface

// File: rtl/ha_array_reducer_row_value.sv
// Weighted value of one ha_array: (t + (b << 2)) << (2k).
module ha_array_row_value
  import ha_array_pkg::*;
(
  input  ha_row_t          row,
  input  logic [1:0]       k,
  output logic [ACC_W-1:0] value_c
);

  logic [ACC_W-1:0] base_c;

  // Combine the two rows, then place the array at its column offset.
  always_comb begin
    base_c  = ACC_W'(row.t) + (ACC_W'(row.b) << B_SHIFT);
    value_c = base_c << (ROW_SHIFT * 32'(k));
  end

endmodule

// File: rtl/ha_array_reducer.sv
// ha_array_reducer: accepts a bundle of four ha_array row pairs and folds
// ROWS_PER_CYCLE arrays per cycle into a 17-bit accumulator, presenting the
// 16-bit product with valid/ready.
// Optional build macro HA_ARRAY_REDUCER_SAT_EN: saturate prod to 16'hFFFF
// when the accumulator overflows 16 bits (ovf reports it in both builds).
module ha_array_reducer
  import ha_array_pkg::*;
#(
  parameter int unsigned ROWS_PER_CYCLE = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  ha_array_reducer_if.slave bus
);

  localparam int unsigned R     = ROWS_PER_CYCLE;
  localparam int unsigned IDX_W = 2;

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rows_per_cycle
    $error("ha_array_reducer: ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  ha_row_t [N_ARRAYS-1:0]     rows_q, rows_d, in_rows_c;
  logic [PROD_W-1:0]          prod_q, prod_d, prod_fin_c;
  logic                       ovf_q, ovf_d;
  logic                       load_c;
  logic                       last_c;
  logic [ACC_W-1:0]           acc_sum_c;
  logic [ACC_W-1:0]           part_c [R+1];

  // Gather the port rows into the packed bundle form.
  always_comb begin
    in_rows_c[0] = '{b: bus.ha_array_0_b, t: bus.ha_array_0_t};
    in_rows_c[1] = '{b: bus.ha_array_1_b, t: bus.ha_array_1_t};
    in_rows_c[2] = '{b: bus.ha_array_2_b, t: bus.ha_array_2_t};
    in_rows_c[3] = '{b: bus.ha_array_3_b, t: bus.ha_array_3_t};
  end

  assign part_c[0] = acc_q;

  // R weighting lanes, chained into the running accumulator sum.
  for (genvar j = 0; j < R; j++) begin : g_lane
    logic [IDX_W-1:0] k_c;
    logic [ACC_W-1:0] value_c;

    assign k_c = idx_q + IDX_W'(j);

    ha_array_row_value u_row_value (
      .row     (rows_q[k_c]),
      .k       (k_c),
      .value_c (value_c)
    );

    assign part_c[j+1] = part_c[j] + value_c;
  end

  assign acc_sum_c = part_c[R];
  assign last_c    = (32'(idx_q) + R == N_ARRAYS);

  // Final product formatting: wrap by default, optional saturation.
`ifdef HA_ARRAY_REDUCER_SAT_EN
  assign prod_fin_c = acc_sum_c[ACC_W-1] ? {PROD_W{1'b1}} : acc_sum_c[PROD_W-1:0];
`else
  assign prod_fin_c = acc_sum_c[PROD_W-1:0];
`endif

  // Next-state, datapath updates and in_ready.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    rows_d       = rows_q;
    prod_d       = prod_q;
    ovf_d        = ovf_q;
    load_c       = 1'b0;
    bus.in_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        load_c       = bus.in_valid;
      end
      ACC: begin
        acc_d = acc_sum_c;
        idx_d = idx_q + IDX_W'(R);
        if (last_c) begin
          state_d = DONE;
          prod_d  = prod_fin_c;
          ovf_d   = acc_sum_c[ACC_W-1];
        end
      end
      DONE: begin
        // A new bundle may enter on the same edge the product leaves.
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      rows_d  = in_rows_c;
      acc_d   = '0;
      idx_d   = '0;
      state_d = ACC;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      rows_q  <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      rows_q  <= rows_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.prod      = prod_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ha_array_reducer.sv
// Directed bench for ha_array_reducer: three instances (R = 1, 2, 4) share
// the row data; each has its own handshake.
module tb_ha_array_reducer;
  import ha_array_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [B_W-1:0]    tb_b [N_ARRAYS];
  logic [T_W-1:0]    tb_t [N_ARRAYS];
  logic [2:0]        in_valid_v;
  logic [2:0]        out_ready_v;
  logic [2:0]        in_ready_v;
  logic [2:0]        out_valid_v;
  logic [2:0]        ovf_v;
  logic [2:0]        busy_v;
  logic [PROD_W-1:0] prod_v [3];
  int                total;
  int                bad;

  ha_array_reducer_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned R_G = 1 << g;

    assign bus[g].in_valid     = in_valid_v[g];
    assign bus[g].out_ready    = out_ready_v[g];
    assign bus[g].ha_array_0_b = tb_b[0];
    assign bus[g].ha_array_1_b = tb_b[1];
    assign bus[g].ha_array_2_b = tb_b[2];
    assign bus[g].ha_array_3_b = tb_b[3];
    assign bus[g].ha_array_0_t = tb_t[0];
    assign bus[g].ha_array_1_t = tb_t[1];
    assign bus[g].ha_array_2_t = tb_t[2];
    assign bus[g].ha_array_3_t = tb_t[3];
    assign in_ready_v[g]       = bus[g].in_ready;
    assign out_valid_v[g]      = bus[g].out_valid;
    assign ovf_v[g]            = bus[g].ovf;
    assign busy_v[g]           = bus[g].busy;
    assign prod_v[g]           = bus[g].prod;

    ha_array_reducer #(.ROWS_PER_CYCLE(R_G)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      tb_t[2'(k)] = '0;
      tb_b[2'(k)] = '0;
    end
  endtask

  function automatic logic [31:0] ref_acc();
    logic [31:0] s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s = s + ((32'(tb_t[2'(k)]) + (32'(tb_b[2'(k)]) << 2)) << (2 * k));
    return s;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [31:0] a);
`ifdef HA_ARRAY_REDUCER_SAT_EN
    if (a[16]) return 16'hFFFF;
`endif
    return a[15:0];
  endfunction

  // Count cycles from the accepting edge to out_valid, then check the result.
  task automatic wait_done(input logic [1:0] g, input int exp_lat, input logic [15:0] exp_prod,
                           input logic exp_ovf, input string tag);
    int lat;
    lat = 0;
    while (!out_valid_v[g] && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_prod"}, 32'(prod_v[g]), 32'(exp_prod));
    check({tag, "_ovf"}, 32'(ovf_v[g]), 32'(exp_ovf));
  endtask

  task automatic release_out(input logic [1:0] g, input string tag);
    out_ready_v[g] = 1'b1;
    tick();
    out_ready_v[g] = 1'b0;
    check({tag, "_vld_low"}, 32'(out_valid_v[g]), 32'd0);
    check({tag, "_idle"}, 32'(busy_v[g]), 32'd0);
  endtask

  task automatic run(input logic [1:0] g, input int exp_lat, input logic [15:0] exp_prod,
                     input logic exp_ovf, input string tag);
    in_valid_v[g] = 1'b1;
    tick();
    in_valid_v[g] = 1'b0;
    check({tag, "_rdy_acc"}, 32'(in_ready_v[g]), 32'd0);
    wait_done(g, exp_lat, exp_prod, exp_ovf, tag);
    release_out(g, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] acc;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    clear_rows();

    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      check("rst_vld", 32'(out_valid_v[2'(g)]), 32'd0);
      check("rst_busy", 32'(busy_v[2'(g)]), 32'd0);
      check("rst_prod", 32'(prod_v[2'(g)]), 32'd0);
      check("rst_ovf", 32'(ovf_v[2'(g)]), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int g = 0; g < 3; g++)
      check("rst_rdy", 32'(in_ready_v[2'(g)]), 32'd1);

    clear_rows();
    run(2'd0, 4, 16'h0000, 1'b0, "zero");

    clear_rows();
    tb_t[0] = 9'h001;
    run(2'd0, 4, 16'h0001, 1'b0, "t0_bit0");

    clear_rows();
    tb_b[3] = 7'h40;
    run(2'd0, 4, 16'h4000, 1'b0, "b3_bit6");

    clear_rows();
    tb_t[1] = 9'h100;
    run(2'd0, 4, 16'h0400, 1'b0, "t1_bit8");

    for (int k = 0; k < 4; k++) begin
      tb_t[2'(k)] = '1;
      tb_b[2'(k)] = '1;
    end
`ifdef HA_ARRAY_REDUCER_SAT_EN
    run(2'd0, 4, 16'hFFFF, 1'b1, "all_ones");
`else
    run(2'd0, 4, 16'h5257, 1'b1, "all_ones");
`endif

    // Backpressure: product must hold while out_ready is low.
    clear_rows();
    tb_t[2] = 9'h003;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    wait_done(2'd0, 4, 16'h0030, 1'b0, "bp_a");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_vld", 32'(out_valid_v[0]), 32'd1);
      check("bp_hold_prod", 32'(prod_v[0]), 32'h30);
      check("bp_hold_rdy", 32'(in_ready_v[0]), 32'd0);
    end
    clear_rows();
    tb_t[0] = 9'h005;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    #1;
    check("bp_rdy_pass", 32'(in_ready_v[0]), 32'd1);
    tick();
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b0;
    check("bp_vld_drop", 32'(out_valid_v[0]), 32'd0);
    check("bp_busy", 32'(busy_v[0]), 32'd1);
    wait_done(2'd0, 4, 16'h0005, 1'b0, "bp_b");
    release_out(2'd0, "bp_b");

    // Asynchronous reset in the middle of accumulation.
    clear_rows();
    tb_t[0] = 9'h007;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid_v[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    check("mid_rst_prod", 32'(prod_v[0]), 32'd0);
    check("mid_rst_ovf", 32'(ovf_v[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy", 32'(in_ready_v[0]), 32'd1);
    clear_rows();
    tb_b[1] = 7'h01;
    run(2'd0, 4, 16'h0010, 1'b0, "post_rst");

    // Latency sweep across R = 1, 2, 4 with random bundles.
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 3; n++) begin
        for (int k = 0; k < 4; k++) begin
          tb_t[2'(k)] = 9'($urandom);
          tb_b[2'(k)] = 7'($urandom);
        end
        acc = ref_acc();
        run(2'(g), 4 >> g, ref_prod(acc), acc[16], "sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
